// File: rtl/cpu_clock_controller_if.sv
// Button, breakpoint, divider-load and clock-enable signals shared between the
// execution controller (slave) and whatever drives its buttons (master).
interface cpu_clock_controller_if #(
  parameter int DIV_WIDTH = 26
);
  logic                 run_req;
  logic                 halt_req;
  logic                 step_req;
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 brk;
  logic                 cpu_en;
  logic                 clk_out;
  logic [1:0]           state;
  logic [15:0]          tick_count;

  modport master (
    output run_req, halt_req, step_req, div_load, div_value, brk,
    input  cpu_en, clk_out, state, tick_count
  );

  modport slave (
    input  run_req, halt_req, step_req, div_load, div_value, brk,
    output cpu_en, clk_out, state, tick_count
  );
endinterface

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step controller producing a one-cycle cpu_en pulse at a programmable rate.
// Define STEP_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on every button.
module cpu_clock_controller #(
  parameter int INPUT_FREQUENCY  = 50_000_000,
  parameter int OUTPUT_FREQUENCY = 1,
  parameter int DIV_WIDTH        = $clog2(INPUT_FREQUENCY),
  parameter int DEBOUNCE_CYCLES  = 1_000_000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  cpu_clock_controller_if.slave bus
);

  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV =
    DIV_WIDTH'(INPUT_FREQUENCY / OUTPUT_FREQUENCY - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Button bit order everywhere below: [0] run, [1] halt, [2] step.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] level;
  logic [2:0] prev_q, prev_d;
  logic [2:0] btn_edge;
  logic       run_edge, halt_edge, step_edge;

  assign btn_raw = {bus.step_req, bus.halt_req, bus.run_req};

`ifdef STEP_DEBOUNCE_EN
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];

  // A button's filtered level only flips after the synchronized level has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign btn_edge  = level & ~prev_q;
  assign run_edge  = btn_edge[0];
  assign halt_edge = btn_edge[1];
  assign step_edge = btn_edge[2];

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
  logic [DIV_WIDTH-1:0] counter_q, counter_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 clk_out_q, clk_out_d;
  logic [15:0]          tick_count_q, tick_count_d;
  logic                 terminal;

  assign terminal = (counter_q == div_reg_q);

  // A halt edge or a breakpoint seen during a pulse beats any terminal count,
  // so halting never lets one more pulse slip out.
  always_comb begin
    state_d   = state_q;
    div_reg_d = div_reg_q;
    counter_d = counter_q;
    cpu_en_d  = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        counter_d = '0;
        if (!halt_edge) begin
          if (step_edge) begin
            state_d  = ST_STEP;
            cpu_en_d = 1'b1;
          end else if (run_edge) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_STEP: begin
        counter_d = '0;
        state_d   = ST_HALT;
      end
      ST_RUN: begin
        if (halt_edge || (bus.brk && cpu_en_q)) begin
          state_d   = ST_HALT;
          counter_d = '0;
        end else if (terminal) begin
          counter_d = '0;
          cpu_en_d  = 1'b1;
        end else begin
          counter_d = counter_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d   = ST_HALT;
        counter_d = '0;
      end
    endcase

    if (bus.div_load) begin
      div_reg_d = bus.div_value;
      counter_d = '0;
    end

    clk_out_d    = clk_out_q ^ cpu_en_d;
    tick_count_d = tick_count_q + 16'(cpu_en_d);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HALT;
      div_reg_q    <= DEFAULT_DIV;
      counter_q    <= '0;
      cpu_en_q     <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_reg_q    <= div_reg_d;
      counter_q    <= counter_d;
      cpu_en_q     <= cpu_en_d;
      clk_out_q    <= clk_out_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.clk_out    = clk_out_q;
  assign bus.state      = state_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: directed button scenarios and random traffic,
// each cycle compared with a pulse-schedule reference model.
module tb_cpu_clock_controller;

  localparam int IN_F    = 100;
  localparam int OUT_F   = 10;
  localparam int DW      = $clog2(IN_F);
  localparam int DEF_DIV = IN_F / OUT_F - 1;
  localparam int DEB     = 8;
  localparam int MAXC    = 16384;
`ifdef STEP_DEBOUNCE_EN
  localparam int OFS   = 3;
  localparam int EXTRA = DEB;
  localparam int HOLD  = DEB;
`else
  localparam int OFS   = 2;
  localparam int EXTRA = 0;
  localparam int HOLD  = 1;
`endif

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  cpu_clock_controller_if #(.DIV_WIDTH(DW)) bus ();

  cpu_clock_controller #(
    .INPUT_FREQUENCY (IN_F),
    .OUTPUT_FREQUENCY(OUT_F),
    .DIV_WIDTH       (DW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: button sample history plus an absolute schedule of the next pulse edge.
  bit          raw_h  [3][MAXC];
  bit          filt_h [3][MAXC];
  int          m_edge;
  int          m_mode;
  bit          m_en;
  int          m_div;
  int          m_next;
  logic [15:0] m_ticks;
  bit          m_clk;
  bit          brk_lvl;
  int          base;

  function automatic bit seen(input int b, input int j);
    if (j < 0) return 1'b0;
`ifdef STEP_DEBOUNCE_EN
    return filt_h[b][j];
`else
    return raw_h[b][j];
`endif
  endfunction

  task automatic model_reset();
    m_edge  = 0;
    m_mode  = 0;
    m_en    = 1'b0;
    m_div   = DEF_DIV;
    m_next  = 0;
    m_ticks = 16'd0;
    m_clk   = 1'b0;
  endtask

  task automatic model_edge();
    bit lv [3];
    bit eg [3];
    bit all_eq;
    bit new_en;
    int idx;
    lv[0] = bus.run_req;
    lv[1] = bus.halt_req;
    lv[2] = bus.step_req;
    for (int b = 0; b < 3; b++) begin
      raw_h[b][m_edge] = lv[b];
      all_eq = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        idx = m_edge - k;
        if (((idx < 0) ? 1'b0 : raw_h[b][idx]) != lv[b]) all_eq = 1'b0;
      end
      filt_h[b][m_edge] = all_eq ? lv[b] : ((m_edge > 0) ? filt_h[b][m_edge-1] : 1'b0);
      eg[b] = seen(b, m_edge - OFS) && !seen(b, m_edge - OFS - 1);
    end

    new_en = 1'b0;
    if (bus.div_load) m_div = int'(bus.div_value);
    case (m_mode)
      0: begin
        if (!eg[1]) begin
          if (eg[2]) begin
            m_mode = 2;
            new_en = 1'b1;
          end else if (eg[0]) begin
            m_mode = 1;
            m_next = m_edge + m_div + 1;
          end
        end
      end
      2: m_mode = 0;
      default: begin
        if (eg[1] || (bus.brk && m_en)) begin
          m_mode = 0;
        end else begin
          if (m_edge == m_next) new_en = 1'b1;
          if (new_en || bus.div_load) m_next = m_edge + m_div + 1;
        end
      end
    endcase
    m_en = new_en;
    if (new_en) begin
      m_ticks = m_ticks + 16'd1;
      m_clk   = ~m_clk;
    end
    m_edge++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, ".state"},      32'(bus.state),      32'(m_mode));
    check_val({tag, ".cpu_en"},     32'(bus.cpu_en),     32'(m_en));
    check_val({tag, ".clk_out"},    32'(bus.clk_out),    32'(m_clk));
    check_val({tag, ".tick_count"}, 32'(bus.tick_count), 32'(m_ticks));
  endtask

  task automatic applyStimulus(input bit r, input bit h, input bit s, input bit bk,
                               input bit ld, input logic [DW-1:0] val);
    bus.run_req   = r;
    bus.halt_req  = h;
    bus.step_req  = s;
    bus.brk       = bk;
    bus.div_load  = ld;
    bus.div_value = val;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, brk_lvl, 1'b0, '0);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic press(input bit r, input bit h, input bit s, input int hold, input string tag);
    applyStimulus(r, h, s, brk_lvl, 1'b0, '0);
    for (int i = 0; i < hold; i++) cycle(tag);
    applyStimulus(1'b0, 1'b0, 1'b0, brk_lvl, 1'b0, '0);
  endtask

  task automatic load_div(input logic [DW-1:0] val, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, brk_lvl, 1'b1, val);
    cycle(tag);
    applyStimulus(1'b0, 1'b0, 1'b0, brk_lvl, 1'b0, '0);
  endtask

  initial begin
    bit r, h, s;
    brk_lvl = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #12;
    checkOutput("reset");
    @(negedge clk_in);
    reset = 1'b0;

    // RUN at the default rate: five pulses ten cycles apart.
    press(1'b1, 1'b0, 1'b0, HOLD, "run");
    idle(55 + EXTRA - HOLD, "run_wait");
    check_val("run5.ticks",   32'(bus.tick_count), 32'd5);
    check_val("run5.clk_out", 32'(bus.clk_out),    32'd1);
    check_val("run5.state",   32'(bus.state),      32'd1);
    press(1'b0, 1'b1, 1'b0, HOLD, "halt");
    idle(5 + EXTRA, "halt_wait");
    check_val("halt.state", 32'(bus.state), 32'd0);

    // Three single steps, then one long press.
    base = int'(m_ticks);
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b0, 1'b1, HOLD, "step");
      idle(6 + EXTRA, "step_wait");
    end
    check_val("step3.ticks", 32'(bus.tick_count), 32'(base + 3));
    press(1'b0, 1'b0, 1'b1, 50, "step_hold");
    idle(5 + EXTRA, "step_hold_wait");
    check_val("stephold.ticks", 32'(bus.tick_count), 32'(base + 4));

    // Breakpoint held through RUN: one pulse then HALT.
    base    = int'(m_ticks);
    brk_lvl = 1'b1;
    press(1'b1, 1'b0, 1'b0, HOLD, "brk_run");
    idle(30 + EXTRA, "brk_wait");
    check_val("brk.state", 32'(bus.state),      32'd0);
    check_val("brk.ticks", 32'(bus.tick_count), 32'(base + 1));
    brk_lvl = 1'b0;

    // div_value=0 gives a pulse every cycle; halt stops it.
    press(1'b1, 1'b0, 1'b0, HOLD, "div0_run");
    idle(4 + EXTRA, "div0_enter");
    load_div('0, "div0_load");
    idle(6, "div0_fast");
    check_val("div0.cpu_en", 32'(bus.cpu_en), 32'd1);
    press(1'b0, 1'b1, 1'b0, HOLD, "div0_halt");
    idle(4 + EXTRA, "div0_halt_wait");
    check_val("div0halt.cpu_en", 32'(bus.cpu_en), 32'd0);
    check_val("div0halt.state",  32'(bus.state),  32'd0);
    load_div(DW'(DEF_DIV), "div_restore");

    // Coincident requests: step beats run in HALT, halt beats run in RUN.
    base = int'(m_ticks);
    press(1'b1, 1'b0, 1'b1, HOLD, "step_run");
    idle(6 + EXTRA, "step_run_wait");
    check_val("steprun.ticks", 32'(bus.tick_count), 32'(base + 1));
    check_val("steprun.state", 32'(bus.state),      32'd0);
    press(1'b1, 1'b0, 1'b0, HOLD, "run_again");
    idle(4 + EXTRA, "run_again_wait");
    press(1'b1, 1'b1, 1'b0, HOLD, "halt_run");
    idle(4 + EXTRA, "halt_run_wait");
    check_val("haltrun.state", 32'(bus.state), 32'd0);

    // Reset while RUN's counter sits at 7.
    press(1'b1, 1'b0, 1'b0, HOLD, "pre_reset_run");
    idle(10 + EXTRA - HOLD, "pre_reset_count");
    reset = 1'b1;
    #1;
    model_reset();
    checkOutput("mid_reset");
    @(negedge clk_in);
    reset = 1'b0;
    idle(20, "post_reset");
    check_val("postreset.ticks", 32'(bus.tick_count), 32'd0);
    check_val("postreset.state", 32'(bus.state),      32'd0);

    // Five-cycle step glitch.
    press(1'b0, 1'b0, 1'b1, 5, "glitch");
    idle(20 + EXTRA, "glitch_wait");
`ifdef STEP_DEBOUNCE_EN
    check_val("glitch.ticks", 32'(bus.tick_count), 32'd0);
`endif

    // Random buttons, breakpoints and divider loads.
    r = 1'b0;
    h = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] val;
      bit ld;
      if ($urandom_range(0, 5) == 0)  r = ~r;
      if ($urandom_range(0, 11) == 0) h = ~h;
      if ($urandom_range(0, 7) == 0)  s = ~s;
      ld  = ($urandom_range(0, 19) == 0);
      val = DW'($urandom_range(0, 4));
      applyStimulus(r, h, s, ($urandom_range(0, 7) == 0), ld, val);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
